// File: rtl/data_pack_pkg.sv
// ---------------------------------------------------------------------------
// data_pack_pkg
// Shared USB link definitions: bag-type encodings, sync bytes, the fill FSM
// state encoding and the checksum helper. Used by the payload stage, the USB
// core and the collect-side controller so every block agrees on the framing.
// ---------------------------------------------------------------------------
package data_pack_pkg;

    // Sync bytes that open every bag; they are excluded from the checksum.
    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;

    // Bag-type encodings carried in the low nibble of header byte 2.
    localparam logic [3:0] BAG_DTEMP = 4'b1010;
    localparam logic [3:0] BAG_DATA0 = 4'b1101;
    localparam logic [3:0] BAG_DATA1 = 4'b1110;

    // Fill FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DATA_H = 3'd3,
        ST_DATA_L = 3'd4,
        ST_SUM    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Only the two DATA types carry an ADC sample block.
    function automatic logic is_data_bag(input logic [3:0] btype);
        return (btype == BAG_DATA0) || (btype == BAG_DATA1);
    endfunction

    // Running checksum: byte-wise XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                             input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/data_pack.sv
// ---------------------------------------------------------------------------
// data_pack
// Upstream payload stage of the USB link. On a fill request it writes one
// complete bag into the USB transmit RAM (sync/type/sequence header, an
// optional block of NUM 16-bit ADC samples, XOR checksum) and then raises
// fd_fill until the controller drops fs_fill.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   fs_fill    fill request (held until fd_fill is seen)
//   fill_btype bag type, captured when the request starts
//   fd_fill    fill done, held until fs_fill falls
//   fill_len   bytes written in the finished bag (valid with fd_fill)
//   adc_data   sample word
//   adc_valid  sample available
//   adc_ready  sample accepted on a rising edge with adc_valid
//   ram_txa    RAM write address (BASE + offset, wraps at 4096)
//   ram_txd    RAM write data
//   ram_txen   RAM write strobe, one byte per high cycle
//
// Every output is a register. The state register names the cycle in which
// its byte is visible on the RAM port, so each transition also registers
// the write (or idle strobe) belonging to the state being entered.
// ---------------------------------------------------------------------------
module data_pack
    import data_pack_pkg::*;
#(
    parameter logic [11:0] NUM  = 12'h040,
    parameter logic [11:0] BASE = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_fill,
    input  logic [3:0]  fill_btype,
    output logic        fd_fill,
    output logic [11:0] fill_len,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic        adc_ready,
    output logic [11:0] ram_txa,
    output logic [7:0]  ram_txd,
    output logic        ram_txen
);

    state_e      state_q;
    logic [3:0]  btype_q;
    logic [7:0]  seq_q;
    logic [7:0]  csum_q;
    logic [11:0] cnt_q;
    logic [11:0] nbytes_q;
    logic [15:0] sample_q;
    logic [1:0]  hidx_q;

    logic        fd_fill_q;
    logic [11:0] fill_len_q;
    logic        adc_ready_q;
    logic [11:0] ram_txa_q;
    logic [7:0]  ram_txd_q;
    logic        ram_txen_q;

    logic [7:0]  hdr_next_s;
    logic [11:0] wr_addr_s;

    // Address of the next byte to be written; 12-bit add wraps modulo 4096.
    assign wr_addr_s = BASE + nbytes_q;

    // Header byte that follows the one currently presented (hidx_q).
    always_comb begin
        hdr_next_s = 8'h00;
        case (hidx_q)
            2'd0:    hdr_next_s = SYNC1;
            2'd1:    hdr_next_s = {4'h0, btype_q};
            2'd2:    hdr_next_s = seq_q;
            default: hdr_next_s = seq_q;
        endcase
    end

    // Fill FSM with its counters, checksum accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            btype_q     <= 4'h0;
            seq_q       <= 8'h00;
            csum_q      <= 8'h00;
            cnt_q       <= 12'h000;
            nbytes_q    <= 12'h000;
            sample_q    <= 16'h0000;
            hidx_q      <= 2'd0;
            fd_fill_q   <= 1'b0;
            fill_len_q  <= 12'h000;
            adc_ready_q <= 1'b0;
            ram_txa_q   <= 12'h000;
            ram_txd_q   <= 8'h00;
            ram_txen_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ram_txen_q  <= 1'b0;
                    adc_ready_q <= 1'b0;
                    if (fs_fill) begin
                        // First header byte goes out on the very next cycle.
                        btype_q    <= fill_btype;
                        csum_q     <= 8'h00;
                        cnt_q      <= 12'h000;
                        hidx_q     <= 2'd0;
                        ram_txen_q <= 1'b1;
                        ram_txa_q  <= BASE;
                        ram_txd_q  <= SYNC0;
                        nbytes_q   <= 12'd1;
                        state_q    <= ST_HEAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_HEAD: begin
                    if (!fs_fill) begin
                        state_q     <= ST_IDLE;
                        ram_txen_q  <= 1'b0;
                        adc_ready_q <= 1'b0;
                    end else if (hidx_q != 2'd3) begin
                        ram_txen_q <= 1'b1;
                        ram_txa_q  <= wr_addr_s;
                        ram_txd_q  <= hdr_next_s;
                        nbytes_q   <= nbytes_q + 12'd1;
                        hidx_q     <= hidx_q + 2'd1;
                        // Bytes 2 and 3 enter the checksum; the sync pair does not.
                        if (hidx_q != 2'd0) begin
                            csum_q <= csum_step(csum_q, hdr_next_s);
                        end else begin
                            csum_q <= csum_q;
                        end
                    end else if (is_data_bag(btype_q)) begin
                        ram_txen_q  <= 1'b0;
                        adc_ready_q <= 1'b1;
                        state_q     <= ST_WAIT;
                    end else begin
                        ram_txen_q <= 1'b1;
                        ram_txa_q  <= wr_addr_s;
                        ram_txd_q  <= csum_q;
                        nbytes_q   <= nbytes_q + 12'd1;
                        state_q    <= ST_SUM;
                    end
                end

                ST_WAIT: begin
                    if (!fs_fill) begin
                        state_q     <= ST_IDLE;
                        ram_txen_q  <= 1'b0;
                        adc_ready_q <= 1'b0;
                    end else if (adc_valid && adc_ready_q) begin
                        sample_q    <= adc_data;
                        adc_ready_q <= 1'b0;
                        ram_txen_q  <= 1'b1;
                        ram_txa_q   <= wr_addr_s;
                        ram_txd_q   <= adc_data[15:8];
                        nbytes_q    <= nbytes_q + 12'd1;
                        csum_q      <= csum_step(csum_q, adc_data[15:8]);
                        state_q     <= ST_DATA_H;
                    end else begin
                        ram_txen_q <= 1'b0;
                    end
                end

                ST_DATA_H: begin
                    if (!fs_fill) begin
                        state_q     <= ST_IDLE;
                        ram_txen_q  <= 1'b0;
                        adc_ready_q <= 1'b0;
                    end else begin
                        ram_txen_q <= 1'b1;
                        ram_txa_q  <= wr_addr_s;
                        ram_txd_q  <= sample_q[7:0];
                        nbytes_q   <= nbytes_q + 12'd1;
                        csum_q     <= csum_step(csum_q, sample_q[7:0]);
                        state_q    <= ST_DATA_L;
                    end
                end

                ST_DATA_L: begin
                    if (!fs_fill) begin
                        state_q     <= ST_IDLE;
                        ram_txen_q  <= 1'b0;
                        adc_ready_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                        if ((cnt_q + 12'd1) == NUM) begin
                            // csum_q already holds the low byte just presented.
                            ram_txen_q <= 1'b1;
                            ram_txa_q  <= wr_addr_s;
                            ram_txd_q  <= csum_q;
                            nbytes_q   <= nbytes_q + 12'd1;
                            state_q    <= ST_SUM;
                        end else begin
                            ram_txen_q  <= 1'b0;
                            adc_ready_q <= 1'b1;
                            state_q     <= ST_WAIT;
                        end
                    end
                end

                ST_SUM: begin
                    ram_txen_q <= 1'b0;
                    if (!fs_fill) begin
                        state_q     <= ST_IDLE;
                        adc_ready_q <= 1'b0;
                    end else begin
                        fd_fill_q  <= 1'b1;
                        fill_len_q <= nbytes_q;
                        seq_q      <= seq_q + 8'd1;
                        state_q    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    ram_txen_q  <= 1'b0;
                    adc_ready_q <= 1'b0;
                    if (!fs_fill) begin
                        fd_fill_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        fd_fill_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    fd_fill_q   <= 1'b0;
                    ram_txen_q  <= 1'b0;
                    adc_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign fd_fill   = fd_fill_q;
    assign fill_len  = fill_len_q;
    assign adc_ready = adc_ready_q;
    assign ram_txa   = ram_txa_q;
    assign ram_txd   = ram_txd_q;
    assign ram_txen  = ram_txen_q;

endmodule

// File: doc/data_pack.md
# data_pack

Upstream payload stage of the USB link. Fills the USB transmit RAM with one complete bag: a sync/type/sequence header, optionally a block of 16-bit ADC samples, and a checksum. It then reports completion to the collect-side controller through the fs/fd handshake. The USB core transmits the bag from the RAM only after the controller has seen `fd_fill` and raised `fs_send`.

## Interface
- `NUM`, default 8'h40: samples per data bag; legal range 1..2045, so the bag fits in 4096 bytes.
- `BASE`, default 12'h000: RAM address of header byte 0.
- `clk` in 1: system clock (50 MHz domain); all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fs_fill` in 1: fill request; held high until `fd_fill` is seen.
- `fill_btype` in 4: bag type; sampled in IDLE on the cycle `fs_fill` is first seen high.
- `fd_fill` out 1: fill done; held high until `fs_fill` falls.
- `fill_len` out 12: total bytes written; valid while `fd_fill` is high.
- `adc_data` in 16: sample word.
- `adc_valid` in 1: sample available.
- `adc_ready` out 1: sample accepted when `adc_valid & adc_ready` is high on a rising edge.
- `ram_txa` out 12: RAM write address.
- `ram_txd` out 8: RAM write data.
- `ram_txen` out 1: RAM write strobe; one byte is written per high cycle.

## Operation
- States: IDLE, HEAD, WAIT, DATA_H, DATA_L, SUM, DONE.
- IDLE
  - On `fs_fill` = 1: latch `fill_btype`, clear `csum`, and go to HEAD.
- HEAD
  - 4 cycles, writing BASE+0 = 8'h55, BASE+1 = 8'hAA, BASE+2 = {4'h0, btype}, BASE+3 = `seq`.
  - Then go to WAIT if btype is 4'b1101 (DATA0) or 4'b1110 (DATA1); otherwise go to SUM.
- WAIT
  - `adc_ready` = 1. On a handshake, latch the sample and go to DATA_H.
- DATA_H
  - Write `sample[15:8]`, then go to DATA_L.
- DATA_L
  - Write `sample[7:0]`.
  - Increment sample count `cnt`. If `cnt` reaches NUM, go to SUM; otherwise go to WAIT.
- SUM
  - Write `csum` at the next address, then go to DONE.
- DONE
  - `fd_fill` = 1 and `fill_len` = the number of bytes written.
  - `seq` increments once on entry, wrapping 8'hFF to 8'h00.
  - When `fs_fill` = 0: `fd_fill` goes to 0 and the state returns to IDLE.
- Checksum
  - `csum` is the XOR of every byte from BASE+2 through the last payload byte.
  - The sync bytes are excluded.
- Address arithmetic
  - The address is `BASE + offset`, 12-bit, wrapping modulo 4096.
  - `fill_len` = 5 for a header-only bag.
  - `fill_len` = 5 + 2·NUM for a data bag; 133 (12'h085) at default.
- Abort
  - If `fs_fill` falls in any state other than IDLE or DONE, return to IDLE the next cycle.
  - On abort: no further writes, `seq` is unchanged, and `fd_fill` is never asserted.
- A `fs_fill` that is still high in IDLE after DONE has exited does not start a new bag. `fs_fill` must be seen low at least one cycle before a new request.

## Timing
- Reset values:
  - State is IDLE.
  - `fd_fill`, `adc_ready`, and `ram_txen` are 0.
  - `ram_txa`, `ram_txd`, and `fill_len` are 0.
  - `seq`, `cnt`, and `csum` are 0.
- Reset mid-fill takes effect immediately; RAM contents are don't-care afterwards.
- All outputs are registered.
- The first `ram_txen` cycle is 1 cycle after `fs_fill` is sampled high in IDLE.
- Write cycles are contiguous through HEAD, and each sample's DATA_H and DATA_L writes are back-to-back.
- Each sample costs at least 3 cycles (WAIT, DATA_H, DATA_L). `adc_ready` is low in DATA_H and DATA_L.
- With `adc_valid` held high, a data bag takes 4 + 3·NUM + 1 cycles from the first write to the SUM write. `fd_fill` rises on the following cycle.
- `adc_valid` low in WAIT stalls indefinitely with no writes.

## Structure
- Bag-type encodings (BAG_INIT, BAG_DATA0, BAG_DATA1, BAG_DTEMP, ...) and the sync bytes 8'h55/8'hAA belong in a shared USB package used by this block, the USB core and the collect controller.
- A sub-module is not needed. The FSM, counters, checksum accumulator and address generator are one module of about 200 lines.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst` = 0, then release.
  - Response: all outputs are 0; with no `fs_fill` there is no `ram_txen` for 100 cycles.
- Header-only bag:
  - Stimulus: `fill_btype` = 4'b1010 (DTEMP), `seq` = 0.
  - Response: bytes 55 AA 0A 00 0A are written at 0..4, `fill_len` = 5, and `fd_fill` rises.
  - After `fs_fill` falls, `fd_fill` falls and `seq` = 1.
- Full data bag:
  - Stimulus: DATA0, `adc_valid` held high, samples 16'h0000..16'h003F.
  - Response: 133 bytes are written; byte 4 = 00 and byte 131 = 3F.
  - The checksum byte equals the XOR of bytes 2..131 computed by the model, and `fill_len` = 12'h085.
- Stalled ADC:
  - Stimulus: toggle `adc_valid` pseudo-randomly during DATA1.
  - Response: the same byte image as with no stalls, and `ram_txen` is never high in WAIT.
- Abort and reset mid-fill:
  - Stimulus: drop `fs_fill` after 10 samples.
  - Response: writes stop within 1 cycle, `fd_fill` stays 0, and the `seq` used by the next bag is unchanged.
  - Stimulus: assert `rst` mid-fill.
  - Response: all outputs return to 0 asynchronously.
- Sequence wrap:
  - Stimulus: 257 consecutive header-only bags.
  - Response: byte 3 runs 00..FF and then 00.
